axi_mem_slave: RTL and testbench

- AXI4 memory-mapped subordinate (slave) backed by a synthesizable word-addressed RAM.
- Serves as the responder end for our AXI master driver, both in simulation and as an on-chip scratch memory.
- Supports single-beat and FIXED/INCR bursts with byte strobes.
- Read and write channels run independently, with one outstanding transaction per direction.

---
 rtl/axi_pkg.sv | 37 +++
 rtl/axi_mem_array.sv | 36 +++
 rtl/axi_mem_slave.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_axi_mem_slave.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI encodings, FSM state types and header-check helper for the
// AXI memory subordinate and its RAM array.
package axi_pkg;

  // AxBURST encodings
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  // xRESP encodings
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // The only supported beat size: 8 bytes
  localparam logic [2:0] SIZE_8B     = 3'd3;

  // Byte lane width used by the strobed RAM
  localparam int BYTE_W = 8;

  // Write-channel FSM states
  typedef logic [1:0] wr_state_t;
  localparam wr_state_t W_IDLE = 2'd0;
  localparam wr_state_t W_DATA = 2'd1;
  localparam wr_state_t W_RESP = 2'd2;

  // Read-channel FSM states
  typedef logic [0:0] rd_state_t;
  localparam rd_state_t R_IDLE = 1'b0;
  localparam rd_state_t R_DATA = 1'b1;

  // A transaction header is unusable if it asks for a WRAP burst (or the
  // reserved burst encoding) or for any beat size other than 8 bytes.
  function automatic logic hdr_err(input logic [1:0] burst, input logic [2:0] size);
    return ((burst != BURST_FIXED) && (burst != BURST_INCR)) || (size != SIZE_8B);
  endfunction

endpackage

// File: rtl/axi_mem_array.sv
// DEPTH x DATA_WIDTH word RAM: one byte-strobed synchronous write port and
// one combinational read port. A read of a word written on the same edge
// sees the old contents, because the read is sampled by the edge that
// performs the write. Contents are deliberately not reset.
module axi_mem_array
  import axi_pkg::*;
#(
  parameter int DEPTH      = 1024,
  parameter int DATA_WIDTH = 64,
  parameter int IDX_W      = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         i_we,
  input  logic [IDX_W-1:0]             i_waddr,
  input  logic [DATA_WIDTH-1:0]        i_wdata,
  input  logic [DATA_WIDTH/BYTE_W-1:0] i_wstrb,
  input  logic [IDX_W-1:0]             i_raddr,
  output logic [DATA_WIDTH-1:0]        o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // Byte-lane write: only lanes whose strobe bit is set are updated
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < DATA_WIDTH / BYTE_W; b++) begin
        if (i_wstrb[b]) begin
          r_mem[i_waddr][b*BYTE_W +: BYTE_W] <= i_wdata[b*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/axi_mem_slave.sv
// AXI4 memory-mapped subordinate backed by axi_mem_array. Independent read
// and write FSMs, one outstanding transaction per direction, FIXED/INCR
// bursts of 8-byte beats with byte strobes. WRAP bursts, sizes other than
// 8 bytes and out-of-range beats answer SLVERR; such write beats are
// dropped and such read beats return zero data.
module axi_mem_slave
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 4,
  parameter int DEPTH      = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  // Write address channel
  input  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [ID_WIDTH-1:0]     S_AXI_AWID,
  input  logic [7:0]              S_AXI_AWLEN,
  input  logic [2:0]              S_AXI_AWSIZE,
  input  logic [1:0]              S_AXI_AWBURST,
  input  logic                    S_AXI_AWVALID,
  output logic                    S_AXI_AWREADY,
  // Write data channel
  input  logic [DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                    S_AXI_WLAST,
  input  logic                    S_AXI_WVALID,
  output logic                    S_AXI_WREADY,
  // Write response channel
  output logic [ID_WIDTH-1:0]     S_AXI_BID,
  output logic [1:0]              S_AXI_BRESP,
  output logic                    S_AXI_BVALID,
  input  logic                    S_AXI_BREADY,
  // Read address channel
  input  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [ID_WIDTH-1:0]     S_AXI_ARID,
  input  logic [7:0]              S_AXI_ARLEN,
  input  logic [2:0]              S_AXI_ARSIZE,
  input  logic [1:0]              S_AXI_ARBURST,
  input  logic                    S_AXI_ARVALID,
  output logic                    S_AXI_ARREADY,
  // Read data channel
  output logic [DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [ID_WIDTH-1:0]     S_AXI_RID,
  output logic [1:0]              S_AXI_RRESP,
  output logic                    S_AXI_RLAST,
  output logic                    S_AXI_RVALID,
  input  logic                    S_AXI_RREADY
);

  localparam int          IDX_W     = $clog2(DEPTH);
  localparam logic [63:0] MEM_BYTES = 64'(DEPTH) * 64'd8;

  // A beat is backed by RAM only if its byte address lies below DEPTH*8.
  function automatic logic f_in_range(input logic [ADDR_WIDTH-1:0] a);
    return 64'(a) < MEM_BYTES;
  endfunction

  // Address of the following beat: FIXED stays put, INCR steps one word.
  function automatic logic [ADDR_WIDTH-1:0] f_next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                        input logic [1:0]            burst);
    return (burst == BURST_FIXED) ? a : a + ADDR_WIDTH'(8);
  endfunction

  // ---------------------------------------------------------------------
  // Write channel state
  // ---------------------------------------------------------------------
  wr_state_t             r_wstate;
  logic                  r_awready;
  logic                  r_wready;
  logic                  r_bvalid;
  logic [ID_WIDTH-1:0]   r_bid;
  logic [1:0]            r_bresp;
  logic [ID_WIDTH-1:0]   r_wid;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [7:0]            r_wcnt;
  logic [1:0]            r_wburst;
  logic                  r_whdr_err;
  logic                  r_werr_acc;

  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic                  w_b_hs;
  logic                  w_wfinal;
  logic                  w_wbeat_bad;
  logic                  w_wlast_bad;
  logic                  w_mem_we;

  assign w_aw_hs     = S_AXI_AWVALID & r_awready;
  assign w_w_hs      = S_AXI_WVALID & r_wready;
  assign w_b_hs      = r_bvalid & S_AXI_BREADY;
  assign w_wfinal    = (r_wcnt == 8'd0);
  assign w_wbeat_bad = r_whdr_err | ~f_in_range(r_waddr);
  // Length comes from AWLEN; WLAST is only cross-checked against it.
  assign w_wlast_bad = (S_AXI_WLAST != w_wfinal);
  assign w_mem_we    = w_w_hs & ~w_wbeat_bad;

  // ---------------------------------------------------------------------
  // Read channel state
  // ---------------------------------------------------------------------
  rd_state_t             r_rstate;
  logic                  r_arready;
  logic                  r_rvalid;
  logic                  r_rlast;
  logic [ID_WIDTH-1:0]   r_rid;
  logic [1:0]            r_rresp;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [ADDR_WIDTH-1:0] r_raddr;
  logic [7:0]            r_rcnt;
  logic [1:0]            r_rburst;
  logic                  r_rhdr_err;

  logic                  w_ar_hs;
  logic                  w_r_hs;
  logic [ADDR_WIDTH-1:0] w_rd_addr;
  logic                  w_rd_hdr_err;
  logic                  w_rd_bad;
  logic [DATA_WIDTH-1:0] w_mem_rdata;
  logic [DATA_WIDTH-1:0] w_rd_beat_data;
  logic [1:0]            w_rd_beat_resp;

  assign w_ar_hs = S_AXI_ARVALID & r_arready;
  assign w_r_hs  = r_rvalid & S_AXI_RREADY;

  // The single RAM read port serves the beat about to be registered: beat 0
  // straight from the AR channel while idle, otherwise the beat after the
  // one currently on the R channel.
  assign w_rd_addr      = (r_rstate == R_IDLE) ? S_AXI_ARADDR : f_next_addr(r_raddr, r_rburst);
  assign w_rd_hdr_err   = (r_rstate == R_IDLE) ? hdr_err(S_AXI_ARBURST, S_AXI_ARSIZE) : r_rhdr_err;
  assign w_rd_bad       = w_rd_hdr_err | ~f_in_range(w_rd_addr);
  assign w_rd_beat_data = w_rd_bad ? '0 : w_mem_rdata;
  assign w_rd_beat_resp = w_rd_bad ? RESP_SLVERR : RESP_OKAY;

  // ---------------------------------------------------------------------
  // RAM
  // ---------------------------------------------------------------------
  axi_mem_array #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_W      (IDX_W)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_waddr (r_waddr[3 +: IDX_W]),
    .i_wdata (S_AXI_WDATA),
    .i_wstrb (S_AXI_WSTRB),
    .i_raddr (w_rd_addr[3 +: IDX_W]),
    .o_rdata (w_mem_rdata)
  );

  // Write FSM and its handshake/response outputs; reset aborts any burst
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bid     <= '0;
      r_bresp   <= RESP_OKAY;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (w_aw_hs) begin
            r_wstate  <= W_DATA;
            r_awready <= 1'b0;
            r_wready  <= 1'b1;
          end else begin
            // Also raises AWREADY on the first edge after reset release
            r_awready <= 1'b1;
          end
        end
        W_DATA: begin
          if (w_w_hs && w_wfinal) begin
            r_wstate <= W_RESP;
            r_wready <= 1'b0;
            r_bvalid <= 1'b1;
            r_bid    <= r_wid;
            r_bresp  <= (r_werr_acc | w_wbeat_bad | w_wlast_bad) ? RESP_SLVERR : RESP_OKAY;
          end
        end
        W_RESP: begin
          if (w_b_hs) begin
            r_wstate  <= W_IDLE;
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
          end
        end
        default: begin
          r_wstate  <= W_IDLE;
          r_awready <= 1'b0;
          r_wready  <= 1'b0;
          r_bvalid  <= 1'b0;
        end
      endcase
    end
  end

  // Write burst bookkeeping: header latch, address/counter stepping, error accumulation
  always_ff @(posedge clk) begin
    if (w_aw_hs) begin
      r_wid      <= S_AXI_AWID;
      r_waddr    <= S_AXI_AWADDR;
      r_wcnt     <= S_AXI_AWLEN;
      r_wburst   <= S_AXI_AWBURST;
      r_whdr_err <= hdr_err(S_AXI_AWBURST, S_AXI_AWSIZE);
      r_werr_acc <= 1'b0;
    end else if (w_w_hs) begin
      r_waddr    <= f_next_addr(r_waddr, r_wburst);
      r_wcnt     <= r_wcnt - 8'd1;
      r_werr_acc <= r_werr_acc | w_wbeat_bad | w_wlast_bad;
    end
  end

  // Read FSM and registered R channel; outputs only move on a handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rid     <= '0;
      r_rresp   <= RESP_OKAY;
      r_rdata   <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (w_ar_hs) begin
            r_rstate  <= R_DATA;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b1;
            r_rid     <= S_AXI_ARID;
            r_rdata   <= w_rd_beat_data;
            r_rresp   <= w_rd_beat_resp;
            r_rlast   <= (S_AXI_ARLEN == 8'd0);
          end else begin
            r_arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (w_r_hs) begin
            if (r_rlast) begin
              r_rstate  <= R_IDLE;
              r_rvalid  <= 1'b0;
              r_rlast   <= 1'b0;
              r_arready <= 1'b1;
            end else begin
              r_rdata   <= w_rd_beat_data;
              r_rresp   <= w_rd_beat_resp;
              r_rlast   <= (r_rcnt == 8'd1);
            end
          end
        end
        default: begin
          r_rstate  <= R_IDLE;
          r_arready <= 1'b0;
          r_rvalid  <= 1'b0;
          r_rlast   <= 1'b0;
        end
      endcase
    end
  end

  // Read burst bookkeeping: r_raddr/r_rcnt track the beat currently presented
  always_ff @(posedge clk) begin
    if (w_ar_hs) begin
      r_raddr    <= S_AXI_ARADDR;
      r_rcnt     <= S_AXI_ARLEN;
      r_rburst   <= S_AXI_ARBURST;
      r_rhdr_err <= hdr_err(S_AXI_ARBURST, S_AXI_ARSIZE);
    end else if (w_r_hs && !r_rlast) begin
      r_raddr    <= f_next_addr(r_raddr, r_rburst);
      r_rcnt     <= r_rcnt - 8'd1;
    end
  end

  assign S_AXI_AWREADY = r_awready;
  assign S_AXI_WREADY  = r_wready;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_BID     = r_bid;
  assign S_AXI_BRESP   = r_bresp;
  assign S_AXI_ARREADY = r_arready;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RLAST   = r_rlast;
  assign S_AXI_RID     = r_rid;
  assign S_AXI_RRESP   = r_rresp;
  assign S_AXI_RDATA   = r_rdata;

endmodule

// File: tb/tb_axi_mem_slave.sv
// Randomized self-checking bench for axi_mem_slave against a word-array
// reference model of the memory and its response rules.
module tb_axi_mem_slave;
  import axi_pkg::*;

  localparam int          AW        = 32;
  localparam int          DW        = 64;
  localparam int          IW        = 4;
  localparam int          DEPTH     = 64;
  localparam int          IDX       = 6;
  localparam logic [31:0] MEM_BYTES = 32'(DEPTH * 8);

  logic clk;
  logic rst_n;
  logic [AW-1:0]   awaddr;  logic [IW-1:0] awid;  logic [7:0] awlen;
  logic [2:0]      awsize;  logic [1:0]    awburst; logic awvalid; logic awready;
  logic [DW-1:0]   wdata;   logic [7:0]    wstrb;  logic wlast; logic wvalid; logic wready;
  logic [IW-1:0]   bid;     logic [1:0]    bresp;  logic bvalid; logic bready;
  logic [AW-1:0]   araddr;  logic [IW-1:0] arid;  logic [7:0] arlen;
  logic [2:0]      arsize;  logic [1:0]    arburst; logic arvalid; logic arready;
  logic [DW-1:0]   rdata;   logic [IW-1:0] rid;   logic [1:0] rresp;
  logic            rlast;   logic          rvalid; logic rready;

  axi_mem_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWID(awid), .S_AXI_AWLEN(awlen), .S_AXI_AWSIZE(awsize),
    .S_AXI_AWBURST(awburst), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast), .S_AXI_WVALID(wvalid),
    .S_AXI_WREADY(wready),
    .S_AXI_BID(bid), .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARID(arid), .S_AXI_ARLEN(arlen), .S_AXI_ARSIZE(arsize),
    .S_AXI_ARBURST(arburst), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RID(rid), .S_AXI_RRESP(rresp), .S_AXI_RLAST(rlast),
    .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference memory and per-beat stimulus buffers
  logic [63:0] mdl [DEPTH];
  logic [63:0] wd  [256];
  logic [7:0]  ws  [256];

  function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [1:0] burst, input int i);
    return (burst == BURST_FIXED) ? a : a + 32'(i) * 32'd8;
  endfunction

  function automatic logic txn_bad(input logic [1:0] burst, input logic [2:0] size);
    return (burst == BURST_WRAP) || (size != 3'd3);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [IW-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst,
                           input int bad_last, input int bready_dly);
    logic        exp_err;
    logic [1:0]  exp_resp;
    logic [31:0] a;
    logic        hs;
    int          cyc;
    exp_err = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      a = beat_addr(addr, burst, i);
      if (txn_bad(burst, size) || a >= MEM_BYTES) exp_err = 1'b1;
      else for (int b = 0; b < 8; b++)
        if (ws[i][b]) mdl[a[3 +: IDX]][b*8 +: 8] = wd[i][b*8 +: 8];
      if (i == bad_last) exp_err = 1'b1;
    end
    exp_resp = exp_err ? 2'b10 : 2'b00;
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    cyc = 0;
    do begin hs = awready; tick(); cyc++; end while (!hs && cyc < 200);
    awvalid = 1'b0;
    if (!hs) begin check_val("aw_timeout", 64'(0), 64'(1)); return; end
    check_val("wready_lat", 64'(wready), 64'(1));
    for (int i = 0; i <= int'(len); i++) begin
      if ($urandom_range(3) == 0) begin wvalid = 1'b0; tick(); end
      wdata = wd[i]; wstrb = ws[i];
      wlast = (i == int'(len)) ^ (i == bad_last);
      wvalid = 1'b1;
      cyc = 0;
      do begin hs = wready; tick(); cyc++; end while (!hs && cyc < 200);
      if (!hs) begin check_val("w_timeout", 64'(0), 64'(1)); wvalid = 1'b0; return; end
    end
    wvalid = 1'b0; wlast = 1'b0;
    check_val("bvalid_lat", 64'(bvalid), 64'(1));
    check_val("bid", 64'(bid), 64'(id));
    check_val("bresp", 64'(bresp), 64'(exp_resp));
    for (int d = 0; d < bready_dly; d++) begin
      tick();
      check_val("b_stable", 64'({bvalid, bid, bresp}), 64'({1'b1, id, exp_resp}));
    end
    bready = 1'b1; tick(); bready = 1'b0;
    check_val("awready_ret", 64'(awready), 64'(1));
  endtask

  // rr_mode: 0 = RREADY held high, 1 = toggling 1,0,1,0..., 2 = random
  task automatic axi_read(input logic [IW-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input int rr_mode);
    logic [63:0] exp_d [256];
    logic [1:0]  exp_r [256];
    logic [31:0] a;
    logic        hs, rr, stalled;
    logic [63:0] held_d;
    logic [63:0] held_m;
    int          cyc, beat;
    for (int i = 0; i <= int'(len); i++) begin
      a = beat_addr(addr, burst, i);
      if (txn_bad(burst, size) || a >= MEM_BYTES) begin exp_d[i] = '0; exp_r[i] = 2'b10; end
      else begin exp_d[i] = mdl[a[3 +: IDX]]; exp_r[i] = 2'b00; end
    end
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    cyc = 0;
    do begin hs = arready; tick(); cyc++; end while (!hs && cyc < 200);
    arvalid = 1'b0;
    if (!hs) begin check_val("ar_timeout", 64'(0), 64'(1)); return; end
    check_val("rvalid_lat", 64'(rvalid), 64'(1));
    beat = 0; cyc = 0; stalled = 1'b0; held_d = '0; held_m = '0;
    while (beat <= int'(len) && cyc < 2000) begin
      case (rr_mode)
        0:       rr = 1'b1;
        1:       rr = (cyc % 2 == 0);
        default: rr = 1'($urandom_range(1));
      endcase
      rready = rr;
      check_val("rvalid", 64'(rvalid), 64'(1));
      if (stalled) begin
        check_val("r_stable_data", rdata, held_d);
        check_val("r_stable_meta", 64'({rlast, rresp, rid}), held_m);
      end
      if (rr) begin
        check_val("rdata", rdata, exp_d[beat]);
        check_val("rresp", 64'(rresp), 64'(exp_r[beat]));
        check_val("rid", 64'(rid), 64'(id));
        check_val("rlast", 64'(rlast), 64'(beat == int'(len)));
        beat++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        held_d  = rdata;
        held_m  = 64'({rlast, rresp, rid});
      end
      tick();
      cyc++;
    end
    rready = 1'b0;
    if (beat <= int'(len)) begin check_val("r_timeout", 64'(0), 64'(1)); return; end
    check_val("arready_ret", 64'(arready), 64'(1));
    check_val("rvalid_drop", 64'(rvalid), 64'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] addr;
    logic [7:0]  len;
    logic [1:0]  burst;
    logic [2:0]  size;
    int          pick, bad_last;

    rst_n = 1'b0;
    awaddr = '0; awid = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arid = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
    rready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_awready", 64'(awready), 64'(0));
    check_val("rst_arready", 64'(arready), 64'(0));
    check_val("rst_wready", 64'(wready), 64'(0));
    check_val("rst_bvalid", 64'({bvalid, bid, bresp}), 64'(0));
    check_val("rst_rvalid", 64'({rvalid, rlast, rid, rresp}), 64'(0));
    check_val("rst_rdata", rdata, 64'(0));
    #2 rst_n = 1'b1;
    #1 check_val("awready_pre_edge", 64'(awready), 64'(0));
    tick();
    check_val("awready_post_rst", 64'(awready), 64'(1));
    check_val("arready_post_rst", 64'(arready), 64'(1));

    // Fill the whole RAM so every later read has a known expectation
    for (int blk = 0; blk < 4; blk++) begin
      for (int i = 0; i < 16; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; end
      axi_write(4'(blk), 32'(blk * 128), 8'd15, SIZE_8B, BURST_INCR, -1, 0);
    end

    // Single-beat write then read
    wd[0] = 64'hDEADBEEF_CAFEF00D; ws[0] = 8'hFF;
    axi_write(4'd5, 32'h10, 8'd0, SIZE_8B, BURST_INCR, -1, 1);
    axi_read(4'd5, 32'h10, 8'd0, SIZE_8B, BURST_INCR, 0);

    // Partial strobe
    wd[0] = 64'h1122334455667788; ws[0] = 8'hFF;
    axi_write(4'd1, 32'h18, 8'd0, SIZE_8B, BURST_INCR, -1, 0);
    wd[0] = 64'hAAAAAAAAAAAAAAAA; ws[0] = 8'h0F;
    axi_write(4'd2, 32'h18, 8'd0, SIZE_8B, BURST_INCR, -1, 0);
    check_val("partial_model", mdl[3], 64'h11223344AAAAAAAA);
    axi_read(4'd2, 32'h18, 8'd0, SIZE_8B, BURST_INCR, 0);

    // INCR burst, read back with toggling RREADY
    for (int i = 0; i < 4; i++) begin wd[i] = 64'(i + 1); ws[i] = 8'hFF; end
    axi_write(4'd3, 32'h100, 8'd3, SIZE_8B, BURST_INCR, -1, 2);
    axi_read(4'd3, 32'h100, 8'd3, SIZE_8B, BURST_INCR, 1);

    // Out-of-range write must not alias onto word 0
    wd[0] = 64'h0BAD0BAD0BAD0BAD; ws[0] = 8'hFF;
    axi_write(4'd6, MEM_BYTES, 8'd0, SIZE_8B, BURST_INCR, -1, 0);
    axi_read(4'd6, 32'h0, 8'd0, SIZE_8B, BURST_INCR, 0);

    // WRAP read, wrong size write, WLAST mismatches, FIXED burst
    axi_read(4'd7, 32'h40, 8'd3, SIZE_8B, BURST_WRAP, 2);
    wd[0] = 64'h1234; ws[0] = 8'hFF; wd[1] = 64'h5678; ws[1] = 8'hFF;
    axi_write(4'd8, 32'h20, 8'd1, 3'd2, BURST_INCR, -1, 0);
    axi_write(4'd9, 32'h28, 8'd1, SIZE_8B, BURST_INCR, 0, 0);
    axi_write(4'd9, 32'h28, 8'd1, SIZE_8B, BURST_INCR, 1, 0);
    wd[0] = 64'h1111111111111111; ws[0] = 8'hFF;
    wd[1] = 64'h2222222222222222; ws[1] = 8'hF0;
    wd[2] = 64'h3333333333333333; ws[2] = 8'h03;
    axi_write(4'd10, 32'h30, 8'd2, SIZE_8B, BURST_FIXED, -1, 0);
    axi_read(4'd10, 32'h30, 8'd2, SIZE_8B, BURST_FIXED, 2);
    axi_read(4'd11, 32'h1E8, 8'd4, SIZE_8B, BURST_INCR, 2);

    // W presented before AW is not consumed
    wdata = 64'hFFFF_FFFF_FFFF_FFFF; wstrb = 8'hFF; wvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin tick(); check_val("no_early_w", 64'(wready), 64'(0)); end
    wvalid = 1'b0;

    // Simultaneous AW and AR on disjoint addresses
    for (int i = 0; i < 4; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'(8'hFF >> i); end
    fork
      axi_write(4'd12, 32'h80, 8'd3, SIZE_8B, BURST_INCR, -1, 1);
      axi_read(4'd13, 32'h180, 8'd5, SIZE_8B, BURST_INCR, 2);
    join
    axi_read(4'd12, 32'h80, 8'd3, SIZE_8B, BURST_INCR, 0);

    // Reset pulsed in the middle of a read burst
    arid = 4'd14; araddr = 32'h0; arlen = 8'd7; arsize = SIZE_8B; arburst = BURST_INCR;
    arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    rready = 1'b1;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    check_val("midrst_rvalid", 64'(rvalid), 64'(0));
    check_val("midrst_readys", 64'({arready, awready, wready, bvalid}), 64'(0));
    rready = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    #1 check_val("midrst_arready_pre", 64'(arready), 64'(0));
    tick();
    check_val("midrst_arready_post", 64'(arready), 64'(1));
    check_val("midrst_rvalid_post", 64'(rvalid), 64'(0));
    axi_read(4'd14, 32'h0, 8'd7, SIZE_8B, BURST_INCR, 0);

    // Randomized traffic
    for (int t = 0; t < 40; t++) begin
      addr = 32'($urandom_range(0, DEPTH + 4)) * 32'd8;
      len  = 8'($urandom_range(0, 7));
      pick = int'($urandom_range(0, 9));
      burst = (pick < 5) ? BURST_INCR : (pick < 9) ? BURST_FIXED : BURST_WRAP;
      size  = ($urandom_range(0, 9) == 0) ? 3'd2 : SIZE_8B;
      if ($urandom_range(0, 1) == 0) begin
        for (int i = 0; i <= int'(len); i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'($urandom); end
        bad_last = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, int'(len))) : -1;
        axi_write(4'($urandom), addr, len, size, burst, bad_last, int'($urandom_range(0, 2)));
      end else begin
        axi_read(4'($urandom), addr, len, size, burst, 2);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
